// File: rtl/cpu_ctrl_pkg.sv
// Shared types and helpers for the CPU run controller.
//   state_e   : controller FSM states
//   cmd_op_e  : host command opcodes
//   reason_e  : end-of-operation reason codes
//   len_decode: 8-bit length field to a 1..256 count (0 means 256)
package cpu_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned REM_W  = 9;
    localparam int unsigned CYC_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_RSVD = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        RSN_NONE    = 2'b00,
        RSN_HALT    = 2'b01,
        RSN_STOP    = 2'b10,
        RSN_TIMEOUT = 2'b11
    } reason_e;

    // A zero length field encodes the maximum count of 256.
    function automatic logic [REM_W-1:0] len_decode(input logic [LEN_W-1:0] len);
        return (len == '0) ? REM_W'(256) : REM_W'(len);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host/debug, program-load, instruction-memory and CPU-control signals of
// the run controller.
//   master: host side (drives commands, load stream, cpu_halt)
//   slave : controller side (drives ready/status, IM write port, CPU pins)
interface cpu_run_ctrl_if #(
    parameter int unsigned IM_AW = 8
);

    logic                              cmd_valid;
    logic                              cmd_ready;
    logic [1:0]                        cmd_op;
    logic [cpu_ctrl_pkg::LEN_W-1:0]    cmd_len;
    logic                              stop_req;
    logic                              ld_valid;
    logic                              ld_ready;
    logic [cpu_ctrl_pkg::DATA_W-1:0]   ld_data;
    logic                              im_we;
    logic [IM_AW-1:0]                  im_addr;
    logic [cpu_ctrl_pkg::DATA_W-1:0]   im_wdata;
    logic                              cpu_halt;
    logic                              cpu_enable;
    logic                              cpu_start;
    logic                              busy;
    logic                              done;
    logic [1:0]                        reason;
    logic [cpu_ctrl_pkg::CYC_W-1:0]    cycle_count;

    modport master (
        output cmd_valid, cmd_op, cmd_len, stop_req, ld_valid, ld_data, cpu_halt,
        input  cmd_ready, ld_ready, im_we, im_addr, im_wdata,
               cpu_enable, cpu_start, busy, done, reason, cycle_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, stop_req, ld_valid, ld_data, cpu_halt,
        output cmd_ready, ld_ready, im_we, im_addr, im_wdata,
               cpu_enable, cpu_start, busy, done, reason, cycle_count
    );

endinterface

// File: rtl/sat_cnt32.sv
// 32-bit saturating up-counter with synchronous clear (clear wins).
//   clock, reset : clock, async active-low reset
//   clr_i        : synchronous clear
//   inc_i        : increment enable, holds at all-ones
//   count_o      : current count
module sat_cnt32
    import cpu_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CYC_W-1:0] count_o
);

    logic [CYC_W-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + CYC_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 16-bit pipelined CPU: loads a program into
// instruction memory, issues the start pulse and gates enable for free-run
// or single-step execution, ending on HALT, host stop or watchdog.
//   clock, reset : clock, async active-low reset
//   bus          : cpu_run_ctrl_if slave (command, load stream, IM write
//                  port, CPU enable/start/halt, status)
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 0,
    parameter int unsigned IM_AW      = 8
) (
    input  logic          clock,
    input  logic          reset,
    cpu_run_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    logic               started_q, started_d;
    logic               is_step_q, is_step_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [IM_AW-1:0]   im_addr_q, im_addr_d;
    logic               done_q, done_d;
    reason_e            reason_q, reason_d;
    logic               cmd_ready_q, ld_ready_q, cpu_enable_q, cpu_start_q, busy_q;

    logic               cmd_fire, wr_fire, cnt_clr, cnt_inc, wd_hit, limit_hit;
    logic [CYC_W-1:0]   cyc_cnt;

    assign cmd_fire = bus.cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
    assign wr_fire  = bus.ld_valid && ld_ready_q;
    assign cnt_clr  = (state_q == ST_START);
    assign cnt_inc  = (state_q == ST_RUN) || (state_q == ST_STEP);

    // Watchdog fires on the enabled cycle that brings the count to the limit.
    assign wd_hit    = (MAX_CYCLES != 32'd0) &&
                       ((33'(cyc_cnt) + 33'd1) >= 33'(MAX_CYCLES));
    assign limit_hit = (state_q == ST_RUN) ? wd_hit : (rem_q == REM_W'(1));

    // Next-state and next-register decode.
    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        is_step_d = is_step_q;
        rem_d     = rem_q;
        im_addr_d = im_addr_q;
        done_d    = 1'b0;
        reason_d  = reason_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op_e'(bus.cmd_op))
                        OP_LOAD: begin
                            state_d   = ST_LOAD;
                            im_addr_d = '0;
                            started_d = 1'b0;
                            rem_d     = len_decode(bus.cmd_len);
                        end
                        OP_RUN, OP_STEP: begin
                            is_step_d = (cmd_op_e'(bus.cmd_op) == OP_STEP);
                            rem_d     = len_decode(bus.cmd_len);
                            if (!started_q) begin
                                state_d = ST_START;
                            end else if (cmd_op_e'(bus.cmd_op) == OP_STEP) begin
                                state_d = ST_STEP;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_LOAD: begin
                if (wr_fire) begin
                    im_addr_d = im_addr_q + IM_AW'(1);
                    rem_d     = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        reason_d = RSN_NONE;
                    end
                end
            end

            ST_START: begin
                started_d = 1'b1;
                state_d   = is_step_q ? ST_STEP : ST_RUN;
            end

            // Exit priority: halt, then stop, then watchdog / step count.
            ST_RUN, ST_STEP: begin
                if (state_q == ST_STEP) begin
                    rem_d = rem_q - REM_W'(1);
                end
                if (bus.cpu_halt) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    reason_d  = RSN_HALT;
                    started_d = 1'b0;
                end else if (bus.stop_req) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    reason_d = RSN_STOP;
                end else if (limit_hit) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    reason_d = (state_q == ST_RUN) ? RSN_TIMEOUT : RSN_NONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State plus outputs registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            started_q    <= 1'b0;
            is_step_q    <= 1'b0;
            rem_q        <= '0;
            im_addr_q    <= '0;
            done_q       <= 1'b0;
            reason_q     <= RSN_NONE;
            cmd_ready_q  <= 1'b0;
            ld_ready_q   <= 1'b0;
            cpu_enable_q <= 1'b0;
            cpu_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            is_step_q    <= is_step_d;
            rem_q        <= rem_d;
            im_addr_q    <= im_addr_d;
            done_q       <= done_d;
            reason_q     <= reason_d;
            cmd_ready_q  <= (state_d == ST_IDLE);
            ld_ready_q   <= (state_d == ST_LOAD);
            cpu_enable_q <= (state_d inside {ST_START, ST_RUN, ST_STEP});
            cpu_start_q  <= (state_d == ST_START);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    sat_cnt32 u_cyc_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (cyc_cnt)
    );

    // Load write path is combinational so a word lands in the cycle it is offered.
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.ld_ready    = ld_ready_q;
    assign bus.im_we       = wr_fire;
    assign bus.im_addr     = im_addr_q;
    assign bus.im_wdata    = bus.ld_data;
    assign bus.cpu_enable  = cpu_enable_q;
    assign bus.cpu_start   = cpu_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.reason      = reason_q;
    assign bus.cycle_count = cyc_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized
// command sequences checked against a transaction-level model.
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int unsigned MAXC = 10;
    localparam int unsigned AW   = 8;

    logic clock = 1'b0;
    logic reset;

    cpu_run_ctrl_if #(.IM_AW(AW)) bus ();

    cpu_run_ctrl #(.MAX_CYCLES(MAXC), .IM_AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    // Model state: whether the CPU is started, and the expected cycle count.
    bit m_started = 1'b0;
    int m_count   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] len);
        int w;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            tick();
            w++;
        end
        chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, 32'({bus.cmd_ready, bus.ld_ready, bus.im_we, bus.cpu_enable,
                      bus.cpu_start, bus.busy, bus.done, bus.reason}), 32'd0);
        chk({tag, "_addr"}, 32'(bus.im_addr), 32'd0);
        chk({tag, "_count"}, bus.cycle_count, 32'd0);
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_count   = 0;
    endtask

    // LOAD of n words (n = 1..256); directed mode uses fixed data and one gap.
    task automatic do_load(input int n, input bit directed);
        int w;
        bit ended;
        logic [15:0] d;
        w = 0;
        ended = 1'b0;
        issue(2'b00, 8'(n));
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!bus.busy) begin
                ended = 1'b1;
                break;
            end
            chk("ld_ready", 32'(bus.ld_ready), 32'd1);
            bus.ld_valid = directed ? (cyc != 2) : ($urandom_range(0, 3) != 0);
            d = directed ? 16'(16'h1000 * (w + 1)) : 16'($urandom);
            bus.ld_data = d;
            #1;
            chk("im_we", 32'(bus.im_we), 32'(bus.ld_valid));
            if (bus.ld_valid) begin
                chk("im_addr", 32'(bus.im_addr), 32'(w % 256));
                chk("im_wdata", 32'(bus.im_wdata), 32'(d));
                w++;
            end
            tick();
        end
        bus.ld_valid = 1'b0;
        chk("load_end", 32'(ended), 32'd1);
        chk("load_words", 32'(w), 32'(n));
        chk("load_done", 32'(bus.done), 32'd1);
        chk("load_reason", 32'(bus.reason), 32'(RSN_NONE));
        chk("load_addr_end", 32'(bus.im_addr), 32'(n % 256));
        chk("load_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        m_started = 1'b0;
    endtask

    // RUN or STEP; halt_at/stop_at give the enabled execution cycle (1-based)
    // on which cpu_halt/stop_req is raised, 0 for never.
    task automatic do_exec(input bit is_step, input int len, input int halt_at, input int stop_at);
        int lim, n, base, k, starts;
        bit need_start, ended;
        logic [1:0] exp_rsn;
        need_start = !m_started;
        base       = need_start ? 0 : m_count;
        if (is_step)                  lim = (len == 0) ? 256 : len;
        else if (base >= int'(MAXC))  lim = 1;
        else                          lim = int'(MAXC) - base;
        n       = lim;
        exp_rsn = is_step ? RSN_NONE : RSN_TIMEOUT;
        if (stop_at > 0 && stop_at <= n) begin
            n = stop_at;
            exp_rsn = RSN_STOP;
        end
        if (halt_at > 0 && halt_at <= n) begin
            n = halt_at;
            exp_rsn = RSN_HALT;
        end

        k = 0;
        starts = 0;
        ended = 1'b0;
        issue(is_step ? 2'b10 : 2'b01, 8'(len));
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (bus.cpu_start) begin
                starts++;
                bus.cpu_halt = 1'b0;
                bus.stop_req = 1'b0;
            end else if (bus.cpu_enable) begin
                k++;
                bus.cpu_halt = (k == halt_at);
                bus.stop_req = (k == stop_at);
            end else begin
                ended = 1'b1;
                break;
            end
            tick();
        end
        bus.cpu_halt = 1'b0;
        bus.stop_req = 1'b0;

        chk("exec_end", 32'(ended), 32'd1);
        chk("exec_starts", 32'(starts), 32'(need_start));
        chk("exec_cycles", 32'(k), 32'(n));
        chk("exec_done", 32'(bus.done), 32'd1);
        chk("exec_busy", 32'(bus.busy), 32'd0);
        chk("exec_reason", 32'(bus.reason), 32'(exp_rsn));
        chk("exec_count", bus.cycle_count, 32'(base + n));
        chk("exec_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        m_count   = base + n;
        m_started = (exp_rsn != RSN_HALT);
    endtask

    task automatic do_reserved();
        issue(2'b11, 8'($urandom));
        chk("rsvd_busy", 32'(bus.busy), 32'd0);
        chk("rsvd_done", 32'(bus.done), 32'd0);
        chk("rsvd_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, ha, sa;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = 8'd0;
        bus.stop_req  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 16'd0;
        bus.cpu_halt  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outs("reset_init");
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        tick();
        chk("post_reset_ready", 32'(bus.cmd_ready), 32'd1);
        model_reset();

        // Directed scenarios.
        do_load(4, 1'b1);
        do_exec(1'b0, 0, 7, 0);
        do_exec(1'b1, 3, 0, 0);
        do_exec(1'b1, 3, 0, 0);
        do_load(1, 1'b0);
        do_exec(1'b0, 0, 0, 0);
        do_load(2, 1'b0);
        do_exec(1'b0, 0, 3, 3);
        do_exec(1'b0, 0, 0, 5);
        do_exec(1'b1, 0, 0, 0);
        do_reserved();
        do_load(256, 1'b0);

        // Reset in the middle of a LOAD after 2 of 5 words.
        issue(2'b00, 8'd5);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h00A1;
        tick();
        bus.ld_data  = 16'h00A2;
        tick();
        chk("rst_ld_addr_pre", 32'(bus.im_addr), 32'd2);
        bus.ld_data = 16'h00A3;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outs("rst_mid_load");
        @(negedge clock);
        bus.ld_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_ld_ready_after", 32'(bus.cmd_ready), 32'd1);
        chk("rst_ld_busy_after", 32'(bus.busy), 32'd0);
        model_reset();

        // Reset in the middle of a RUN; the next RUN must restart the CPU.
        issue(2'b01, 8'd0);
        repeat (3) tick();
        chk("rst_run_busy_pre", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outs("rst_mid_run");
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("rst_run_ready_after", 32'(bus.cmd_ready), 32'd1);
        model_reset();
        do_exec(1'b0, 0, 4, 0);

        // Randomized command mix.
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            ha = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            sa = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            if (r < 2)       do_load($urandom_range(1, 12), 1'b0);
            else if (r < 6)  do_exec(1'b0, 0, ha, sa);
            else if (r < 9)  do_exec(1'b1, $urandom_range(0, 7), ha, sa);
            else             do_reserved();
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
